if_stage_fetch: RTL and testbench

// - Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of ID_stage.
// - Owns the PC and runs a req/ack handshake to instruction memory.
// - Honours hazard freeze, EXE-stage branch redirect and flush.
// - Emits {PC+4, Instruction, valid} to the decode stage.

---
 rtl/if_stage_fetch.sv | 161 ++++++++++++++++
 tb/tb_if_stage_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC and runs a req/ack handshake to instruction memory. It honours
// the hazard freeze, EXE-stage branch redirects and flushes.
// Optional build macro: IF_PERF_CNT_EN adds a saturating freeze/stall counter
// on port stall_cnt.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IF_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [31:0]       Branch_Address,
    input  logic              flush,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       PC_ID,
    output logic [31:0]       Instruction_ID,
    output logic              valid_ID
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StHold = 2'd1,
        StDrop = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic [31:0] drop_addr_q;
    logic [31:0] hold_q;
    logic [31:0] pc_id_q;
    logic [31:0] instr_id_q;
    logic        valid_id_q;

    logic [31:0] pc_plus4;
    logic        ack_taken;
    logic        capture;
    logic [31:0] capture_word;

    assign pc_plus4  = pc_q + 32'd4;
    // req_q is low in the first cycle after reset, so a stray ack there is ignored
    assign ack_taken = req_q & imem_ack;

    // Decide whether a fetched word enters IF/ID this cycle, and which word
    always_comb begin
        capture      = 1'b0;
        capture_word = imem_rdata;
        if (!Branch_taken && !freeze) begin
            if (state_q == StReq && ack_taken) begin
                capture = 1'b1;
            end else if (state_q == StHold) begin
                capture      = 1'b1;
                capture_word = hold_q;
            end
        end
    end

    // Fetch FSM: PC, request line, hold buffer and the in-flight address to drop
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StReq;
            req_q       <= 1'b0;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'h0;
            hold_q      <= 32'h0;
        end else if (Branch_taken) begin
            pc_q <= Branch_Address;
            req_q <= 1'b1;
            // An unanswered request must still complete at its old address
            if (req_q && !imem_ack) begin
                state_q <= StDrop;
                if (state_q == StReq) begin
                    drop_addr_q <= pc_q;
                end
            end else begin
                state_q <= StReq;
            end
        end else begin
            unique case (state_q)
                StReq: begin
                    req_q <= 1'b1;
                    if (ack_taken) begin
                        if (freeze) begin
                            hold_q  <= imem_rdata;
                            state_q <= StHold;
                            req_q   <= 1'b0;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                end
                StHold: begin
                    if (!freeze) begin
                        pc_q    <= pc_plus4;
                        state_q <= StReq;
                        req_q   <= 1'b1;
                    end
                end
                StDrop: begin
                    if (ack_taken) begin
                        state_q <= StReq;
                    end
                end
                default: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                end
            endcase
        end
    end

    // IF/ID register: branch/flush clear it, otherwise load on capture or hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_id_q    <= 32'h0;
            instr_id_q <= 32'h0;
            valid_id_q <= 1'b0;
        end else if (Branch_taken || flush) begin
            instr_id_q <= 32'h0;
            valid_id_q <= 1'b0;
        end else if (capture) begin
            pc_id_q    <= pc_plus4;
            instr_id_q <= capture_word;
            valid_id_q <= 1'b1;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of cycles lost to freeze or to the hold/drop states
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if ((freeze || state_q != StReq) && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign imem_req       = req_q;
    assign imem_addr      = (state_q == StDrop) ? drop_addr_q : pc_q;
    assign PC_ID          = pc_id_q;
    assign Instruction_ID = instr_id_q;
    assign valid_ID       = valid_id_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Self-checking bench for if_stage_fetch: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_if_stage_fetch;

    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] Branch_Address;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] Instruction_ID;
    logic        valid_ID;
`ifdef IF_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    if_stage_fetch #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .Branch_taken  (Branch_taken),
        .Branch_Address(Branch_Address),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .PC_ID         (PC_ID),
        .Instruction_ID(Instruction_ID),
        .valid_ID      (valid_ID)
`ifdef IF_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: fetch progress tracked as transactions
    logic [31:0] m_pc, m_disc_addr, m_held, m_pc_id, m_instr;
    bit          m_blank, m_held_v, m_disc, m_valid;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic deliver(input logic [31:0] w);
        if (!flush) begin
            m_pc_id = m_pc + 32'd4;
            m_instr = w;
            m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
    endtask

    task automatic model_edge();
        bit req_now, got;
        if (!rst) begin
            m_pc = RESET_PC; m_blank = 1'b1; m_held_v = 1'b0; m_disc = 1'b0;
            m_disc_addr = 32'h0; m_held = 32'h0; m_pc_id = 32'h0; m_instr = 32'h0;
            m_valid = 1'b0; m_cnt = 16'h0;
            return;
        end
        if ((freeze || m_held_v || m_disc) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        req_now = !m_blank && !m_held_v;
        got     = req_now && imem_ack;
        m_blank = 1'b0;
        if (Branch_taken) begin
            m_valid = 1'b0; m_instr = 32'h0; m_held_v = 1'b0;
            if (req_now && !got) begin
                if (!m_disc) m_disc_addr = m_pc;
                m_disc = 1'b1;
            end else begin
                m_disc = 1'b0;
            end
            m_pc = Branch_Address;
        end else begin
            if (flush) begin
                m_valid = 1'b0; m_instr = 32'h0;
            end
            if (m_disc) begin
                if (got) m_disc = 1'b0;
            end else if (m_held_v) begin
                if (!freeze) begin
                    deliver(m_held);
                    m_held_v = 1'b0;
                end
            end else if (got) begin
                if (freeze) begin
                    m_held = imem_rdata; m_held_v = 1'b1;
                end else begin
                    deliver(imem_rdata);
                end
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req", imem_req, (!m_blank && !m_held_v));
        chk("imem_addr", imem_addr, m_disc ? m_disc_addr : m_pc);
        chk("valid_ID", valid_ID, m_valid);
        chk("Instruction_ID", Instruction_ID, m_instr);
        chk("PC_ID", PC_ID, m_pc_id);
`ifdef IF_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Drive inputs; the memory acks only while a request is visible
    task automatic drive(input bit r, input bit fr, input bit br, input logic [31:0] ba,
                         input bit fl, input bit ack_en);
        rst            = r;
        freeze         = fr;
        Branch_taken   = br;
        Branch_Address = ba;
        flush          = fl;
        imem_ack       = (imem_req === 1'b1) && ack_en;
        imem_rdata     = imem_addr ^ KEY;
    endtask

    initial begin
        drive(0, 0, 0, 32'h0, 0, 0);
        cycle();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", valid_ID, 0);
        chk("rst_pcid", PC_ID, 0);
        cycle();

        // Streaming fetch with an ack every cycle
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("req_rise", imem_req, 1);
        chk("addr0", imem_addr, 0);
        chk("first_edge_valid", valid_ID, 0);
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("second_edge_valid", valid_ID, 1);
        chk("pcid4", PC_ID, 32'd4);
        chk("instr0", Instruction_ID, 32'h0 ^ KEY);
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("pcid8", PC_ID, 32'd8);
        chk("addr8", imem_addr, 32'd8);

        // Ack at PC=8 under freeze, held for three cycles
        drive(1, 1, 0, 32'h0, 0, 1); cycle();
        chk("hold_req", imem_req, 0);
        drive(1, 1, 0, 32'h0, 0, 0); cycle();
        drive(1, 1, 0, 32'h0, 0, 0); cycle();
        chk("hold_instr", Instruction_ID, 32'd4 ^ KEY);
        chk("hold_pcid", PC_ID, 32'd8);
        drive(1, 0, 0, 32'h0, 0, 0); cycle();
        chk("release_instr", Instruction_ID, 32'd8 ^ KEY);
        chk("release_pcid", PC_ID, 32'd12);
        chk("release_addr", imem_addr, 32'd12);

        // Branch while a request is outstanding; its ack arrives two cycles later
        drive(1, 0, 1, 32'h100, 0, 0); cycle();
        chk("br_valid", valid_ID, 0);
        chk("drop_addr", imem_addr, 32'd12);
        drive(1, 0, 0, 32'h0, 0, 0); cycle();
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("br_newaddr", imem_addr, 32'h100);
        chk("br_still_invalid", valid_ID, 0);
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("br_pcid", PC_ID, 32'h104);
        chk("br_instr", Instruction_ID, 32'h100 ^ KEY);

        // Flush coinciding with a capture
        drive(1, 0, 0, 32'h0, 1, 1); cycle();
        chk("flush_valid", valid_ID, 0);
        chk("flush_instr", Instruction_ID, 0);
        chk("flush_addr", imem_addr, 32'h108);
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("after_flush_pcid", PC_ID, 32'h10C);

        // PC wrap at the top of the address space
        drive(1, 0, 1, 32'hFFFF_FFFC, 0, 1); cycle();
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        drive(1, 0, 0, 32'h0, 0, 1); cycle();
        chk("wrap_pcid", PC_ID, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset, then freeze for five cycles without traffic
        drive(0, 0, 0, 32'h0, 0, 0); cycle();
        chk("rst2_valid", valid_ID, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 32'h0, 0, 0); cycle();
        end
`ifdef IF_PERF_CNT_EN
        chk("cnt5", stall_cnt, 5);
`endif
        drive(0, 0, 0, 32'h0, 0, 0); cycle();
`ifdef IF_PERF_CNT_EN
        chk("cnt_clear", stall_cnt, 0);
`endif
        chk("rst3_valid", valid_ID, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 7,
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                              : $urandom(),
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 60);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
